// File: rtl/afu_mmio_pkg.sv
// Shared types and constants for the MMIO CSR/FIFO AFU: a minimal CCI-P
// channel subset, DFH constants, FIFO window offsets and STATUS/CTRL bit positions.
package afu_mmio_pkg;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef logic [27:0] t_ccip_c0_RspMemHdr;
    typedef logic [27:0] t_ccip_c1_RspMemHdr;
    typedef logic [73:0] t_ccip_c0_ReqMemHdr;
    typedef logic [79:0] t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    localparam logic [15:0] ADDR_DFH       = 16'h0000;
    localparam logic [15:0] ADDR_AFU_ID_L  = 16'h0002;
    localparam logic [15:0] ADDR_AFU_ID_H  = 16'h0004;
    localparam logic [15:0] ADDR_DFH_RSVD0 = 16'h0006;
    localparam logic [15:0] ADDR_DFH_RSVD1 = 16'h0008;

    localparam logic [15:0] FIFO_OFF_POP    = 16'h0000;
    localparam logic [15:0] FIFO_OFF_STATUS = 16'h0002;
    localparam logic [15:0] FIFO_OFF_PEEK   = 16'h0004;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_UNDERFLOW = 3;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CTRL_CLR   = 0;
    localparam int CTRL_FLUSH = 1;

    // AFU feature header: type=AFU, end-of-list set, everything else zero.
    localparam logic [63:0] DFH_VALUE = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    function automatic logic [63:0] make_status(
        input logic [7:0] count,
        input logic       underflow,
        input logic       overflow,
        input logic       full,
        input logic       empty
    );
        logic [63:0] s;
        s = '0;
        s[STATUS_COUNT_LSB +: 8] = count;
        s[STATUS_UNDERFLOW]      = underflow;
        s[STATUS_OVERFLOW]       = overflow;
        s[STATUS_FULL]           = full;
        s[STATUS_EMPTY]          = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with a combinational head output; push when full and pop
// when empty are ignored, and flush overrides both.
module mmio_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/mmio_csr_fifo.sv
// MMIO CSR space of the AFU: DFH/AFU_ID, a bank of user registers and a
// host-accessible FIFO with status, peek, sticky error flags and flush.
module mmio_csr_fifo
    import afu_mmio_pkg::*;
#(
    parameter int           NUM_USER_REGS = 4,
    parameter int           FIFO_DEPTH    = 8,
    parameter int           FIFO_W        = 64,
    parameter logic [15:0]  USER_BASE     = 16'h0020,
    parameter logic [15:0]  FIFO_BASE     = 16'h0040,
    parameter logic [127:0] AFU_ID        = 128'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  t_if_ccip_Rx rx,
    output t_if_ccip_Tx tx
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W    = (NUM_USER_REGS > 1) ? $clog2(NUM_USER_REGS) : 1;
    localparam int USER_END = int'(USER_BASE) + 2 * NUM_USER_REGS;
    localparam int FIFO_END = int'(FIFO_BASE) + 6;

    if (NUM_USER_REGS < 1 || NUM_USER_REGS > 16) begin : g_chk_regs
        $error("NUM_USER_REGS must be in 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (FIFO_W < 1 || FIFO_W > 64) begin : g_chk_width
        $error("FIFO_W must be in 1..64");
    end
    if (!(FIFO_END <= int'(USER_BASE) || int'(FIFO_BASE) >= USER_END)) begin : g_chk_overlap
        $error("FIFO window overlaps the user register region");
    end

    t_ccip_c0_ReqMmioHdr hdr;
    logic [15:0]         addr;
    logic                rd_req;
    logic                wr_req;
    logic [63:0]         wr_data;

    logic [15:0]         user_off;
    logic                user_hit;
    logic [IDX_W-1:0]    user_idx;
    logic [15:0]         fifo_off;
    logic                pop_hit;
    logic                status_hit;
    logic                peek_hit;

    logic [63:0]         user_regs [NUM_USER_REGS];
    logic                overflow;
    logic                underflow;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic [FIFO_W-1:0]   fifo_dout;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic [63:0]         rd_data;
    logic                rsp_valid;
    logic [8:0]          rsp_tid;
    logic [63:0]         rsp_data;

    logic                unused_rx;

    assign unused_rx = ^{rx.c0TxAlmFull, rx.c1TxAlmFull, rx.c1, rx.c0.rspValid,
                         rx.c0.data[511:64], hdr.length, hdr.rsvd};

    // A write that collides with a read is dropped; only the read is served.
    always_comb begin
        hdr        = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
        addr       = hdr.address;
        wr_data    = rx.c0.data[63:0];
        rd_req     = rx.c0.mmioRdValid;
        wr_req     = rx.c0.mmioWrValid && !rx.c0.mmioRdValid;

        user_off   = addr - USER_BASE;
        user_hit   = (addr >= USER_BASE) && (user_off < 16'(2 * NUM_USER_REGS)) && !user_off[0];
        user_idx   = user_off[IDX_W:1];

        fifo_off   = addr - FIFO_BASE;
        pop_hit    = (addr >= FIFO_BASE) && (fifo_off == FIFO_OFF_POP);
        status_hit = (addr >= FIFO_BASE) && (fifo_off == FIFO_OFF_STATUS);
        peek_hit   = (addr >= FIFO_BASE) && (fifo_off == FIFO_OFF_PEEK);

        fifo_push  = wr_req && pop_hit;
        fifo_pop   = rd_req && pop_hit;
        fifo_flush = wr_req && status_hit && wr_data[CTRL_FLUSH];
    end

    mmio_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (wr_data[FIFO_W-1:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rd_data = '0;
        if (addr == ADDR_DFH) begin
            rd_data = DFH_VALUE;
        end else if (addr == ADDR_AFU_ID_L) begin
            rd_data = AFU_ID[63:0];
        end else if (addr == ADDR_AFU_ID_H) begin
            rd_data = AFU_ID[127:64];
        end else if (user_hit) begin
            rd_data = user_regs[user_idx];
        end else if (pop_hit || peek_hit) begin
            rd_data = fifo_empty ? 64'h0 : 64'(fifo_dout);
        end else if (status_hit) begin
            rd_data = make_status(8'(fifo_count), underflow, overflow, fifo_full, fifo_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_USER_REGS; i++) begin
                user_regs[i] <= '0;
            end
        end else if (wr_req && user_hit) begin
            user_regs[user_idx] <= wr_data;
        end
    end

    // Set and clear never coincide: clears come from writes, underflow from reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && status_hit && wr_data[CTRL_CLR]) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end
            if (fifo_pop && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_req;
            if (rd_req) begin
                rsp_tid  <= hdr.tid;
                rsp_data <= rd_data;
            end
        end
    end

    always_comb begin
        tx                = '0;
        tx.c2.mmioRdValid = rsp_valid;
        tx.c2.hdr.tid     = rsp_tid;
        tx.c2.data        = rsp_data;
    end

endmodule

// File: tb/tb_mmio_csr_fifo.sv
// Scoreboard bench for mmio_csr_fifo: reads push expected responses into a
// queue, and a negedge monitor pops and compares every returned response.
module tb_mmio_csr_fifo;
    import afu_mmio_pkg::*;

    localparam logic [15:0]  UB    = 16'h0020;
    localparam logic [15:0]  FB    = 16'h0040;
    localparam logic [127:0] AFUID = 128'hFEDC_BA98_7654_3210_0011_2233_4455_6677;
    localparam logic [63:0]  DFH   = 64'h1000_0100_0000_0000;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;

    exp_t        exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [8:0]  next_tid   = 9'd5;

    always #5 clk = ~clk;

    mmio_csr_fifo #(
        .NUM_USER_REGS (4),
        .FIFO_DEPTH    (8),
        .FIFO_W        (64),
        .USER_BASE     (UB),
        .FIFO_BASE     (FB),
        .AFU_ID        (AFUID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx)
    );

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (tx.c2.mmioRdValid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_rsp: got tid=%0d data=%h, required no response",
                         tx.c2.hdr.tid, tx.c2.data);
            end else begin
                e = exp_q.pop_front();
                if (tx.c2.hdr.tid !== e.tid || tx.c2.data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL %s: got tid=%0d data=%h, required tid=%0d data=%h",
                             e.name, tx.c2.hdr.tid, tx.c2.data, e.tid, e.data);
                end
            end
            compared++;
            if (tx.c0.valid !== 1'b0 || tx.c1.valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_channels: got c0.valid=%b c1.valid=%b, required 0 0",
                         tx.c0.valid, tx.c1.valid);
            end
        end
    end

    task automatic mmio_write(input logic [15:0] addr, input logic [63:0] data);
        t_ccip_c0_ReqMmioHdr h;
        h               = '0;
        h.address       = addr;
        rx              = '0;
        rx.c0.hdr       = h;
        rx.c0.data[63:0] = data;
        rx.c0.mmioWrValid = 1'b1;
        @(posedge clk);
        #1;
        rx = '0;
    endtask

    task automatic mmio_read(input logic [15:0] addr, input logic [63:0] expect_data,
                             input string name);
        t_ccip_c0_ReqMmioHdr h;
        h         = '0;
        h.address = addr;
        h.tid     = next_tid;
        exp_q.push_back('{tid: next_tid, data: expect_data, name: name});
        next_tid  = next_tid + 9'd1;
        rx        = '0;
        rx.c0.hdr = h;
        rx.c0.mmioRdValid = 1'b1;
        @(posedge clk);
        #1;
        rx = '0;
    endtask

    // Read and write presented together: only the read may take effect.
    task automatic mmio_read_write(input logic [15:0] addr, input logic [63:0] wdata,
                                   input logic [63:0] expect_data, input string name);
        t_ccip_c0_ReqMmioHdr h;
        h         = '0;
        h.address = addr;
        h.tid     = next_tid;
        exp_q.push_back('{tid: next_tid, data: expect_data, name: name});
        next_tid  = next_tid + 9'd1;
        rx        = '0;
        rx.c0.hdr = h;
        rx.c0.data[63:0]  = wdata;
        rx.c0.mmioRdValid = 1'b1;
        rx.c0.mmioWrValid = 1'b1;
        @(posedge clk);
        #1;
        rx = '0;
    endtask

    task automatic check_output(input string name);
        @(negedge clk);
        compared++;
        if (tx !== '0) begin
            mismatched++;
            $display("[TB] FAIL %s: got c2.valid=%b tid=%0d data=%h c0.valid=%b c1.valid=%b, required all zero",
                     name, tx.c2.mmioRdValid, tx.c2.hdr.tid, tx.c2.data, tx.c0.valid, tx.c1.valid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset_tx");

        // DFH / AFU_ID region
        mmio_read(16'h0000, DFH, "dfh");
        mmio_read(16'h0006, 64'h0, "dfh_rsvd0");
        mmio_read(16'h0008, 64'h0, "dfh_rsvd1");
        mmio_read(16'h0002, 64'h0011_2233_4455_6677, "afu_id_lo");
        mmio_read(16'h0004, 64'hFEDC_BA98_7654_3210, "afu_id_hi");
        mmio_write(16'h0000, 64'hFFFF_FFFF_FFFF_FFFF);
        mmio_read(16'h0000, DFH, "dfh_after_write");

        // User registers
        mmio_write(UB + 16'd6, 64'hDEAD_BEEF);
        mmio_read(UB + 16'd6, 64'hDEAD_BEEF, "user3");
        mmio_read(UB + 16'd0, 64'h0, "user0_zero");
        mmio_read(UB + 16'd2, 64'h0, "user1_zero");
        mmio_read(UB + 16'd4, 64'h0, "user2_zero");
        mmio_write(UB + 16'd8, 64'h1234);
        mmio_read(UB + 16'd8, 64'h0, "user_past_end");
        mmio_read(UB + 16'd7, 64'h0, "user_odd_addr");
        mmio_write(UB + 16'd0, 64'h1111_2222_3333_4444);
        mmio_read(UB + 16'd0, 64'h1111_2222_3333_4444, "user0");
        mmio_read_write(UB + 16'd2, 64'h55, 64'h0, "rd_wr_collision");
        mmio_read(UB + 16'd2, 64'h0, "collision_write_dropped");

        // Fill to full, overflow, drain in order
        for (int i = 1; i <= 8; i++) mmio_write(FB, 64'(i));
        mmio_read(FB + 16'd2, 64'h0802, "status_full");
        mmio_write(FB, 64'd9);
        mmio_read(FB + 16'd2, 64'h0806, "status_overflow");
        for (int i = 1; i <= 8; i++) mmio_read(FB, 64'(i), "pop_order");
        mmio_read(FB + 16'd2, 64'h0005, "status_drained");

        // Underflow and sticky clear
        mmio_read(FB, 64'h0, "pop_empty");
        mmio_read(FB + 16'd2, 64'h000D, "status_underflow");
        mmio_write(FB + 16'd2, 64'h1);
        mmio_read(FB + 16'd2, 64'h0001, "status_cleared");

        // Peek, pop, flush
        mmio_write(FB, 64'hA);
        mmio_write(FB, 64'hB);
        mmio_read(FB + 16'd4, 64'hA, "peek1");
        mmio_read(FB + 16'd4, 64'hA, "peek2");
        mmio_read(FB + 16'd2, 64'h0200, "status_after_peek");
        mmio_read(FB, 64'hA, "pop_a");
        mmio_read(FB + 16'd2, 64'h0100, "status_one");
        mmio_write(FB + 16'd2, 64'h2);
        mmio_read(FB + 16'd2, 64'h0001, "status_flushed");
        mmio_read(FB + 16'd4, 64'h0, "peek_empty");
        mmio_read(FB + 16'd2, 64'h0001, "peek_empty_no_flag");

        // Wrap: one entry ahead, 20 interleaved push/pop pairs
        mmio_write(FB, 64'h100);
        for (int i = 1; i <= 20; i++) begin
            mmio_write(FB, 64'h100 + 64'(i));
            mmio_read(FB, 64'h100 + 64'(i - 1), "wrap_pop");
        end
        mmio_read(FB, 64'h114, "wrap_last");
        mmio_read(FB + 16'd2, 64'h0001, "status_wrap_end");

        // Reset while the FIFO holds data and a read is presented
        mmio_write(UB + 16'd2, 64'h77);
        for (int i = 0; i < 3; i++) mmio_write(FB, 64'h30 + 64'(i));
        mmio_read(FB + 16'd2, 64'h0300, "status_three");
        rst = 1'b1;
        rx  = '0;
        rx.c0.hdr = t_ccip_c0_RspMemHdr'(t_ccip_c0_ReqMmioHdr'{address: FB + 16'd2, length: 2'b0, rsvd: 1'b0, tid: 9'd99});
        rx.c0.mmioRdValid = 1'b1;
        @(posedge clk);
        #1;
        rx  = '0;
        rst = 1'b0;
        check_output("reset_mid_tx");
        mmio_read(FB + 16'd2, 64'h0001, "status_after_reset");
        mmio_read(UB + 16'd2, 64'h0, "user1_after_reset");
        mmio_read(UB + 16'd6, 64'h0, "user3_after_reset");
        mmio_read(UB + 16'd0, 64'h0, "user0_after_reset");

        repeat (4) @(posedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL missing_rsp: got %0d outstanding, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
